io_in_arbiter: RTL and testbench

- Shares the processor's single input port among NSRC external word sources.
- Each source has a one-word holding register with a valid/ready handshake.
- A round-robin scheduler moves held words into a presentation register that drives the processor's io_in.
- Pulses itr when a new word is presented; the processor consumes it by asserting req_in. Sits between the peripheral sources and the processor wrapper's io_in/req_in/itr pins.

---
 rtl/io_in_arbiter.sv | 142 ++++++++++++++
 tb/tb_io_in_arbiter.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/io_in_arbiter.sv
// io_in_arbiter: shares the processor's single input word among NSRC sources.
// Each source owns a one-word holding register (valid/ready). A round-robin
// scheduler moves held words into the registered io_in and pulses itr. The
// processor consumes the presented word with req_in.
// Optional build macro: IO_ARB_TAG_EN adds the src_tag output, which carries
// the index of the source whose word is on io_in.
module io_in_arbiter #(
    parameter int NUBITS = 32,
    parameter int NSRC = 4,
    localparam int SW = $clog2(NSRC)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NSRC-1:0]        s_valid,
    input  logic [NSRC*NUBITS-1:0] s_data,
    output logic [NSRC-1:0]        s_ready,
    input  logic                   req_in,
    output logic [NUBITS-1:0]      io_in,
    output logic                   itr,
    output logic                   urun
`ifdef IO_ARB_TAG_EN
    ,
    output logic [SW-1:0]          src_tag
`endif
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t                   state;
    state_t                   state_next;
    logic [NSRC-1:0]          hold_v;
    logic [NSRC*NUBITS-1:0]   hold_data;
    logic [SW-1:0]            rr_ptr;
    logic [SW-1:0]            grant;
    logic [SW-1:0]            ptr_next;
    logic [NSRC-1:0]          rot_v;
    logic [NUBITS-1:0]        grant_word;
    logic                     any_hold;
    logic                     load;
    int                       offset;
    int                       sum;

    assign s_ready    = ~hold_v;
    assign any_hold   = |hold_v;
    assign grant_word = hold_data[grant*NUBITS +: NUBITS];
    assign ptr_next   = (grant == SW'(NSRC - 1)) ? '0 : grant + 1'b1;

    // Round-robin pick: first holding register with a word, starting at rr_ptr.
    always_comb begin
        rot_v  = NSRC'({hold_v, hold_v} >> rr_ptr);
        offset = 0;
        for (int k = NSRC - 1; k >= 0; k--) begin
            if (rot_v[k]) begin
                offset = k;
            end
        end
        sum = int'(rr_ptr) + offset;
        if (sum >= NSRC) begin
            sum = sum - NSRC;
        end
        grant = SW'(sum);
    end

    // Scheduler: load a new word when the presentation slot is free or being consumed.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        case (state)
            EMPTY: begin
                if (any_hold) begin
                    load       = 1'b1;
                    state_next = FULL;
                end
            end
            FULL: begin
                if (req_in) begin
                    if (any_hold) begin
                        load = 1'b1;
                    end else begin
                        state_next = EMPTY;
                    end
                end
            end
            default: state_next = EMPTY;
        endcase
    end

    // Scheduler state register; FULL means a word is currently presented.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // Holding registers: accept from empty slots, drain the granted slot on load.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_v    <= '0;
            hold_data <= '0;
        end else begin
            for (int i = 0; i < NSRC; i++) begin
                if (load && (grant == SW'(i))) begin
                    hold_v[i] <= 1'b0;
                end else if (s_valid[i] && !hold_v[i]) begin
                    hold_v[i]                     <= 1'b1;
                    hold_data[i*NUBITS +: NUBITS] <= s_data[i*NUBITS +: NUBITS];
                end
            end
        end
    end

    // Presentation register, interrupt pulse, fairness pointer and underrun flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            io_in   <= '0;
            itr     <= 1'b0;
            urun    <= 1'b0;
            rr_ptr  <= '0;
`ifdef IO_ARB_TAG_EN
            src_tag <= '0;
`endif
        end else begin
            itr <= load;
            if (load) begin
                io_in   <= grant_word;
                rr_ptr  <= ptr_next;
`ifdef IO_ARB_TAG_EN
                src_tag <= grant;
`endif
            end
            if ((state == EMPTY) && req_in) begin
                urun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_io_in_arbiter.sv
// tb_io_in_arbiter: scoreboard bench for io_in_arbiter. Stimulus pushes the
// expected presented words; a monitor pops and compares on every itr pulse.
module tb_io_in_arbiter;

    localparam int NUBITS = 32;
    localparam int NSRC = 4;
    localparam int SW = 2;

    typedef struct packed {
        logic [NUBITS-1:0] data;
        logic [SW-1:0]     tag;
    } expect_t;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [NSRC-1:0]        s_valid;
    logic [NSRC*NUBITS-1:0] s_data;
    logic [NSRC-1:0]        s_ready;
    logic                   req_in;
    logic [NUBITS-1:0]      io_in;
    logic                   itr;
    logic                   urun;
`ifdef IO_ARB_TAG_EN
    logic [SW-1:0]          src_tag;
`endif

    expect_t exp_q[$];
    int      n_compared = 0;
    int      n_mismatch = 0;

    io_in_arbiter #(
        .NUBITS(NUBITS),
        .NSRC(NSRC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .s_valid(s_valid),
        .s_data(s_data),
        .s_ready(s_ready),
        .req_in(req_in),
        .io_in(io_in),
        .itr(itr),
        .urun(urun)
`ifdef IO_ARB_TAG_EN
        ,
        .src_tag(src_tag)
`endif
    );

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatch++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic expectWord(input logic [31:0] d, input logic [SW-1:0] t);
        expect_t e;
        e.data = d;
        e.tag  = t;
        exp_q.push_back(e);
    endtask

    task automatic applyStimulus(input int src, input logic [31:0] d);
        @(negedge clk);
        s_valid[src] = 1'b1;
        s_data[src*NUBITS +: NUBITS] = d;
        @(posedge clk);
        #1;
        s_valid[src] = 1'b0;
    endtask

    task automatic pulseReq();
        @(negedge clk);
        req_in = 1'b1;
        @(posedge clk);
        #1;
        req_in = 1'b0;
    endtask

    task automatic applyReset();
        @(negedge clk);
        #2;
        rst = 1'b0;
        s_valid = '0;
        req_in = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic waitItr(input string name);
        bit seen;
        seen = 1'b0;
        for (int c = 0; c < 50 && !seen; c++) begin
            @(negedge clk);
            if (itr === 1'b1) seen = 1'b1;
        end
        checkOutput(name, 32'(itr), 32'd1);
    endtask

    // Monitor: every presented word must match the oldest expected word.
    always @(negedge clk) begin
        if (rst === 1'b1 && itr === 1'b1) begin
            if (exp_q.size() == 0) begin
                checkOutput("itr_without_expected_word", 32'(itr), 32'd0);
            end else begin
                expect_t e;
                e = exp_q.pop_front();
                checkOutput("io_in_word", io_in, e.data);
`ifdef IO_ARB_TAG_EN
                checkOutput("src_tag", 32'(src_tag), 32'(e.tag));
`endif
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    logic [9:0] itr_seen;
    int         c0;
    int         c3;
    bit         a0;
    bit         a3;
    int         stable;
    int         extra_itr;

    // Directed test sequence.
    initial begin
        rst = 1'b1;
        s_valid = '0;
        s_data = '0;
        req_in = 1'b0;
        #2;
        rst = 1'b0;
        #10;
        checkOutput("reset_io_in", io_in, 32'd0);
        checkOutput("reset_itr", 32'(itr), 32'd0);
        checkOutput("reset_urun", 32'(urun), 32'd0);
        checkOutput("reset_s_ready", 32'(s_ready), 32'hF);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("ready_after_release", 32'(s_ready), 32'hF);

        // Single word from source 2.
        expectWord(32'h0000_00A5, 2'd2);
        applyStimulus(2, 32'h0000_00A5);
        @(negedge clk);
        checkOutput("t1_itr_not_yet", 32'(itr), 32'd0);
        checkOutput("t1_ready2_low", 32'(s_ready[2]), 32'd0);
        @(negedge clk);
        checkOutput("t1_itr_pulse", 32'(itr), 32'd1);
        checkOutput("t1_ready2_back", 32'(s_ready[2]), 32'd1);
        checkOutput("t1_io_in", io_in, 32'hA5);
        @(negedge clk);
        checkOutput("t1_itr_single", 32'(itr), 32'd0);
        pulseReq();

        // All four sources valid: round-robin order.
        applyReset();
        expectWord(32'd10, 2'd0);
        expectWord(32'd20, 2'd1);
        expectWord(32'd30, 2'd2);
        expectWord(32'd40, 2'd3);
        expectWord(32'd10, 2'd0);
        @(negedge clk);
        s_data = {32'd40, 32'd30, 32'd20, 32'd10};
        s_valid = 4'hF;
        for (int w = 0; w < 5; w++) begin
            waitItr("t2_itr");
            if (w < 4) pulseReq();
        end
        s_valid = '0;
        repeat (3) @(negedge clk);

        // Sources 0 and 3 streaming with req_in held high.
        applyReset();
        for (int k = 0; k < 3; k++) begin
            expectWord(32'h100 + 32'(k), 2'd0);
            expectWord(32'h300 + 32'(k), 2'd3);
        end
        c0 = 0;
        c3 = 0;
        itr_seen = '0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            itr_seen[k] = itr;
            req_in = 1'b1;
            s_valid[0] = (c0 < 3);
            s_data[31:0] = 32'h100 + 32'(c0);
            s_valid[3] = (c3 < 3);
            s_data[127:96] = 32'h300 + 32'(c3);
            a0 = s_valid[0] & s_ready[0];
            a3 = s_valid[3] & s_ready[3];
            @(posedge clk);
            if (a0) c0++;
            if (a3) c3++;
        end
        #1;
        req_in = 1'b0;
        s_valid = '0;
        checkOutput("t3_itr_pattern", 32'(itr_seen), 32'h0FC);

        // Underrun while empty.
        applyReset();
        checkOutput("t4_urun_clear", 32'(urun), 32'd0);
        pulseReq();
        @(negedge clk);
        checkOutput("t4_urun_set", 32'(urun), 32'd1);
        checkOutput("t4_io_in_zero", io_in, 32'd0);
        checkOutput("t4_no_itr", 32'(itr), 32'd0);
        repeat (5) @(negedge clk);
        checkOutput("t4_urun_sticky", 32'(urun), 32'd1);
        expectWord(32'h55, 2'd1);
        applyStimulus(1, 32'h55);
        waitItr("t4_itr");
        checkOutput("t4_urun_after_load", 32'(urun), 32'd1);

        // Presented word held while the processor stalls.
        applyReset();
        expectWord(32'h1234, 2'd0);
        applyStimulus(0, 32'h1234);
        waitItr("t5_first_itr");
        expectWord(32'hBEEF, 2'd1);
        applyStimulus(1, 32'hBEEF);
        stable = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (io_in === 32'h1234 && itr === 1'b0) stable++;
        end
        checkOutput("t5_io_in_stable", 32'(stable), 32'd20);
        checkOutput("t5_ready1_low", 32'(s_ready[1]), 32'd0);
        pulseReq();
        @(negedge clk);
        checkOutput("t5_itr_after_req", 32'(itr), 32'd1);
        checkOutput("t5_next_word", io_in, 32'hBEEF);

        // Asynchronous reset with a presented word and two full holds.
        applyReset();
        expectWord(32'h777, 2'd0);
        applyStimulus(0, 32'h777);
        waitItr("t6_first_itr");
        @(negedge clk);
        s_valid = 4'b0110;
        s_data[63:32] = 32'h1111;
        s_data[95:64] = 32'h2222;
        @(posedge clk);
        #1;
        s_valid = '0;
        @(negedge clk);
        checkOutput("t6_holds_full", 32'(s_ready), 32'h9);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("t6_async_io_in", io_in, 32'd0);
        checkOutput("t6_async_itr", 32'(itr), 32'd0);
        checkOutput("t6_async_ready", 32'(s_ready), 32'hF);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        extra_itr = 0;
        repeat (10) begin
            @(negedge clk);
            if (itr === 1'b1) extra_itr++;
        end
        checkOutput("t6_no_itr_after_reset", 32'(extra_itr), 32'd0);
        checkOutput("t6_ready_after_release", 32'(s_ready), 32'hF);
        expectWord(32'h3333, 2'd3);
        applyStimulus(3, 32'h3333);
        waitItr("t6_new_word_itr");

        repeat (3) @(negedge clk);
        checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
        $finish;
    end

endmodule
